// File: rtl/rx_iq_packer.sv
// -----------------------------------------------------------------------------
// rx_iq_packer
//
// Receive-path byte packer. Each strobed 24-bit I/Q pair is written into a
// small sample FIFO. A serializer pops one sample at a time and sends it as an
// 8-bit valid/ready stream, MSB first:
//     I[23:16] I[15:8] I[7:0] Q[23:16] Q[15:8] Q[7:0] (mic[15:8] mic[7:0])
// When the host stalls for longer than the FIFO can absorb, new samples are
// dropped. A sticky overflow flag and a saturating drop counter report this.
//
// Build option:
//   IQ_PACK_MIC_EN  when defined, each sample also carries mic_data. The
//                   sample is then 8 bytes long instead of 6. The port list is
//                   the same in both builds.
//
// Parameters:
//   DEPTH           FIFO capacity in samples (power of two, >= 2)
//
// Ports:
//   clock           receiver clock
//   rst             asynchronous, active-high reset
//   in_strobe       one-cycle pulse qualifying in_I / in_Q / mic_data
//   in_I, in_Q      24-bit signed sample pair
//   mic_data        16-bit mic sample (used only with IQ_PACK_MIC_EN)
//   out_data        current output byte
//   out_valid       out_data is valid
//   out_ready       consumer accepts the byte when out_valid & out_ready
//   out_last        marks the final byte of each sample
//   level           samples in the FIFO, not counting the one being sent
//   overflow        sticky flag: at least one sample was dropped
//   drop_count      number of dropped samples, saturates at 255
//   clear_overflow  synchronous clear of overflow and drop_count
// -----------------------------------------------------------------------------
module rx_iq_packer #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     in_strobe,
    input  logic [23:0]              in_I,
    input  logic [23:0]              in_Q,
    input  logic [15:0]              mic_data,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clear_overflow
);

`ifdef IQ_PACK_MIC_EN
    localparam int NBYTES = 8;
`else
    localparam int NBYTES = 6;
`endif
    localparam int W     = NBYTES * 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Sample record
    // ------------------------------------------------------------------
    logic [W-1:0] wr_data;
`ifdef IQ_PACK_MIC_EN
    assign wr_data = {in_I, in_Q, mic_data};
`else
    assign wr_data = {in_I, in_Q};
    // mic_data is not packed in this build.
    logic unused_mic;
    assign unused_mic = ^mic_data;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-9:0]     rest_q;      // bytes of the current sample not yet on out_data
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic             overflow_q;
    logic             overflow_d;
    logic [7:0]       drop_count_q;
    logic [7:0]       drop_count_d;

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    logic         accept;
    logic         last_accept;
    logic         fifo_empty;
    logic         fifo_full;
    logic         pop;
    logic         wr_en;
    logic         drop;
    logic [W-1:0] head;

    assign accept      = out_valid_q & out_ready;
    assign last_accept = accept & (idx_q == LAST_IDX);
    assign fifo_empty  = (level_q == '0);
    assign fifo_full   = (level_q == LW'(DEPTH));

    // The serializer loads the head when it is idle. It also loads the head
    // when the last byte is accepted, so consecutive samples have no gap.
    assign pop   = !fifo_empty && ((state_q == ST_IDLE) || last_accept);
    // When the FIFO is full, a pop on the same edge frees the slot that the
    // write will use.
    assign wr_en = in_strobe && (!fifo_full || pop);
    assign drop  = in_strobe && fifo_full && !pop;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // A drop that happens on the same edge as a clear takes priority, so the
    // counter restarts at 1 instead of 0.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)
                drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF)
                drop_count_d = drop_count_q + 8'd1;
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Sample storage (no reset; the pointers define which entries are valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM. All outputs are registered here. out_ready only
    // affects the next state, so it has no combinational path to any output.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rest_q      <= '0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (pop) begin
                state_q     <= ST_SEND;
                idx_q       <= '0;
                out_data_q  <= head[W-1 -: 8];
                rest_q      <= head[W-9:0];
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    ST_SEND: begin
                        if (accept) begin
                            if (idx_q == LAST_IDX) begin
                                state_q     <= ST_IDLE;
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                            end else begin
                                idx_q      <= idx_q + IDX_W'(1);
                                out_data_q <= rest_q[W-9 -: 8];
                                rest_q     <= {rest_q[W-17:0], 8'h00};
                                out_last_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
                            end
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rx_iq_packer.sv
// -----------------------------------------------------------------------------
// tb_rx_iq_packer
//
// Directed, table-driven bench for rx_iq_packer (DEPTH = 8). The sample table
// holds the inputs together with the expected packed byte sequences, which
// were computed by hand. Hand-written sequences cover back-to-back samples,
// a stalled consumer with overflow and counter saturation, clear/drop
// priority, and reset in the middle of a sample.
// Build with +define+IQ_PACK_MIC_EN for the 8-byte variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_iq_packer;

`ifdef IQ_PACK_MIC_EN
    localparam int N = 8;
`else
    localparam int N = 6;
`endif
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_strobe = 1'b0;
    logic [23:0] in_I = '0;
    logic [23:0] in_Q = '0;
    logic [15:0] mic_data = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clear_overflow = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    rx_iq_packer #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .rst            (rst),
        .in_strobe      (in_strobe),
        .in_I           (in_I),
        .in_Q           (in_Q),
        .mic_data       (mic_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    // Each record holds the inputs and the full expected 8-byte stream. The
    // 6-byte build uses only the first six bytes.
    typedef struct {
        logic [23:0] i;
        logic [23:0] q;
        logic [15:0] mic;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    logic [63:0] st_exp [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] e, input int k);
        logic [63:0] t;
        t = e << (8 * k);
        return t[63:56];
    endfunction

    task automatic drive(input logic [23:0] i, input logic [23:0] q, input logic [15:0] m);
        in_I      = i;
        in_Q      = q;
        mic_data  = m;
        in_strobe = 1'b1;
    endtask

    // Called at a negedge with the serializer idle and out_ready = 1.
    task automatic do_single(input vec_t v, input string tag);
        drive(v.i, v.q, v.mic);
        @(negedge clock);
        in_strobe = 1'b0;
        chk({tag, "_cycle1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clock);
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clock);
            chk($sformatf("%s_b%0d_valid", tag, k), 64'(out_valid), 64'd1);
            chk($sformatf("%s_b%0d_data", tag, k), 64'(out_data), 64'(exp_byte(v.exp, k)));
            chk($sformatf("%s_b%0d_last", tag, k), 64'(out_last), 64'(k == N - 1));
        end
        @(negedge clock);
        chk({tag, "_after_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{24'h123456, 24'hABCDEF, 16'h0A0B, 64'h1234_56AB_CDEF_0A0B};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 16'hFFFF, 64'h8000_007F_FFFF_FFFF};
        vecs[2] = '{24'h000001, 24'hFFFFFE, 16'h8001, 64'h0000_01FF_FFFE_8001};
        vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 16'h1234, 64'hA5A5_A55A_5A5A_1234};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);

        // ---------------- single samples from the table ----------------
        for (int v = 0; v < 4; v++)
            do_single(vecs[v], $sformatf("single%0d", v));

        // ---------------- four samples spaced N cycles, no bubbles ----------------
        fork
            begin
                for (int v = 0; v < 4; v++) begin
                    drive(vecs[v].i, vecs[v].q, vecs[v].mic);
                    @(negedge clock);
                    in_strobe = 1'b0;
                    repeat (N - 1) @(negedge clock);
                end
            end
            begin
                int t;
                t = 0;
                while (!out_valid && t < 20) begin
                    @(negedge clock);
                    t++;
                end
                chk("b2b_start_seen", 64'(out_valid), 64'd1);
                for (int b = 0; b < 4 * N; b++) begin
                    if (b > 0) @(negedge clock);
                    chk($sformatf("b2b_byte%0d_valid", b), 64'(out_valid), 64'd1);
                    chk($sformatf("b2b_byte%0d_data", b), 64'(out_data),
                        64'(exp_byte(vecs[b / N].exp, b % N)));
                    chk($sformatf("b2b_byte%0d_last", b), 64'(out_last), 64'((b % N) == N - 1));
                end
                @(negedge clock);
                chk("b2b_end_valid", 64'(out_valid), 64'd0);
            end
        join
        chk("b2b_level", 64'(level), 64'd0);

        // ---------------- stalled consumer, overflow ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 13; k++)
            st_exp[k] = {24'h100000 + 24'(k) * 24'h010101, 24'hF00000 + 24'(k), 16'h0100 + 16'(k)};
        for (int k = 0; k < 12; k++) begin
            drive(st_exp[k][63:40], st_exp[k][39:16], st_exp[k][15:0]);
            @(negedge clock);
            in_strobe = 1'b0;
            @(negedge clock);
        end
        chk("stall_level", 64'(level), 64'd8);
        chk("stall_overflow", 64'(overflow), 64'd1);
        chk("stall_drop_count", 64'(drop_count), 64'd3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk($sformatf("stall_hold%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("stall_hold%0d_data", c), 64'(out_data), 64'(exp_byte(st_exp[0], 0)));
            chk($sformatf("stall_hold%0d_last", c), 64'(out_last), 64'd0);
        end

        // saturate the drop counter
        drive(24'h777777, 24'h777777, 16'h7777);
        repeat (260) @(negedge clock);
        in_strobe = 1'b0;
        @(negedge clock);
        chk("sat_drop_count", 64'(drop_count), 64'd255);
        chk("sat_level", 64'(level), 64'd8);

        // a drop on the same edge as a clear takes priority
        drive(st_exp[12][63:40], st_exp[12][39:16], st_exp[12][15:0]);
        clear_overflow = 1'b1;
        @(negedge clock);
        in_strobe = 1'b0;
        clear_overflow = 1'b0;
        chk("clr_drop_overflow", 64'(overflow), 64'd1);
        chk("clr_drop_count", 64'(drop_count), 64'd1);

        // clear on its own
        clear_overflow = 1'b1;
        @(negedge clock);
        clear_overflow = 1'b0;
        chk("clr_only_overflow", 64'(overflow), 64'd0);
        chk("clr_only_count", 64'(drop_count), 64'd0);

        // release: exactly 9 samples in order
        out_ready = 1'b1;
        for (int b = 0; b < 9 * N; b++) begin
            chk($sformatf("drain_byte%0d_valid", b), 64'(out_valid), 64'd1);
            chk($sformatf("drain_byte%0d_data", b), 64'(out_data), 64'(exp_byte(st_exp[b / N], b % N)));
            chk($sformatf("drain_byte%0d_last", b), 64'(out_last), 64'((b % N) == N - 1));
            @(negedge clock);
        end
        chk("drain_end_valid", 64'(out_valid), 64'd0);
        chk("drain_end_level", 64'(level), 64'd0);

        // ---------------- reset in the middle of a sample ----------------
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            drive(vecs[v].i, vecs[v].q, vecs[v].mic);
            @(negedge clock);
        end
        in_strobe = 1'b0;
        @(negedge clock);
        chk("mid_level_before", 64'(level), 64'd2);
        chk("mid_byte0", 64'(out_data), 64'(exp_byte(vecs[0].exp, 0)));
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("mid_byte3", 64'(out_data), 64'(exp_byte(vecs[0].exp, 3)));
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        @(negedge clock);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clock);
                if (out_valid) seen++;
            end
            chk("post_rst_silent_cycles_with_valid", 64'(seen), 64'd0);
        end
        chk("post_rst_level", 64'(level), 64'd0);
        do_single(vecs[3], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_iq_packer.md
# rx_iq_packer

Receive-path byte packer between the receiver decimation chain and the host framing logic. Captures each strobed 24-bit I/Q output pair into a small sample FIFO and serializes samples MSB-first into an 8-bit stream with a valid/ready handshake. Provides overflow reporting when the host side stalls longer than the FIFO can absorb.

## Interface
Parameters:
- DEPTH, 8, FIFO capacity in samples; power of two, minimum 2.

Ports:
- clock  in  1  receiver clock, 61.44 MHz
- rst  in  1  asynchronous, active-high reset
- in_strobe  in  1  one-cycle pulse; in_I/in_Q (and mic_data) valid
- in_I  in  24  signed I sample
- in_Q  in  24  signed Q sample
- mic_data  in  16  mic sample, captured with in_strobe; ignored unless IQ_PACK_MIC_EN
- out_data  out  8  current byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte when out_valid & out_ready at rising edge
- out_last  out  1  high with the final byte of each sample
- level  out  $clog2(DEPTH)+1  samples held in FIFO, excluding the one in the serializer
- overflow  out  1  sticky; a sample was dropped
- drop_count  out  8  dropped-sample count, saturates at 255
- clear_overflow  in  1  synchronous clear of overflow and drop_count

## Operation
- Sample record: {in_I, in_Q} (48 bits); {in_I, in_Q, mic_data} (64 bits) with IQ_PACK_MIC_EN. Bytes per sample, N = 6 or 8.
- Byte order: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0], then mic[15:8], mic[7:0] when enabled.
- Serializer states:
  - IDLE: out_valid=0. Loads the FIFO head when level>0, then goes to SEND with byte index 0.
  - SEND: presents byte[idx]. On accept, idx increments. On accept of byte N-1: if FIFO is non-empty, the next head is loaded on the same edge (no bubble) with idx=0; otherwise the serializer returns to IDLE.
- out_data and out_last are held stable while out_valid & !out_ready.
- Pop occurs on the edge where the serializer loads. Write occurs on in_strobe when !full, or when full and a pop happens on the same edge.
- Drop: in_strobe while full with no same-edge pop. The new sample is discarded, overflow is set to 1, and drop_count increments, saturating at 255.
- clear_overflow clears overflow and drop_count. If a drop coincides with the clear, the drop wins: overflow=1 and drop_count=1.
- level updates as +1 for a write, -1 for a pop, 0 for both on the same edge.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, level=0, overflow=0, drop_count=0, serializer in IDLE, FIFO pointers 0.
- Reset asserted mid-sample discards the partial sample and all FIFO contents. out_valid drops asynchronously.
- Latency with an empty FIFO and idle serializer: in_strobe high in cycle 0; write at end of cycle 0; load at end of cycle 1; out_valid=1 with byte 0 in cycle 2.
- Throughput: one byte per cycle while out_ready=1. Sustained input rate must not exceed one sample per N cycles; the FIFO absorbs bursts up to DEPTH samples plus the one in the serializer.
- Capacity: total buffered samples = DEPTH in FIFO + 1 in serializer.
- All outputs are registered; there is no combinational path from out_ready to out_valid or out_data.

## Configuration
- IQ_PACK_MIC_EN defined: N=8, and mic bytes are appended after Q.
- IQ_PACK_MIC_EN undefined: N=6, mic_data is unused, and FIFO width is 48 bits.
- Port list is identical in both builds.

## Test plan
- Single sample I=0x123456, Q=0xABCDEF, mic=0x0A0B (MIC_EN), out_ready=1 -> bytes 12 34 56 AB CD EF 0A 0B starting cycle 2; out_last only on 0B; out_valid=0 after.
- Same sample without MIC_EN -> 6 bytes ending EF with out_last; 7th cycle out_valid=0.
- Four strobes spaced 8 cycles, out_ready=1 -> 32 contiguous bytes with no bubbles between samples; level returns to 0.
- out_ready=0 throughout, DEPTH=8, 12 strobes -> 9 samples held (level=8), overflow=1, drop_count=3; out_data stays 0x12-equivalent first byte, stable.
- In the saturated stall state, pulse clear_overflow together with a strobe -> overflow=1, drop_count=1. Then release out_ready -> exactly 9 samples emitted, in order.
- Assert rst on byte 3 of a sample with 2 queued -> outputs are immediately at reset values; after release, no bytes are emitted until a new strobe.
